// File: rtl/max_pool_33.sv
// -----------------------------------------------------------------------------
// max_pool_33
//   Streaming 3x3 max-pooling with stride 2 and no padding over one square
//   feature-map channel of D x D IEEE-754 single-precision pixels. Pixels
//   arrive in raster order, one per accepted cycle. One pooled maximum is
//   produced per window, in raster order, one cycle after the pixel that
//   completes the window.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   valid_in   pxl_in is accepted on this rising edge
//   pxl_in     input pixel (raster order)
//   pxl_out    pooled maximum (holds its value while valid_out is low)
//   valid_out  pxl_out carries a new result this cycle
// -----------------------------------------------------------------------------
module max_pool_33 #(
  parameter int D          = 299,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef logic [data_width-1:0] pix_t;

  // Order-preserving key: negative patterns are inverted, positive patterns get
  // the sign bit set, so an unsigned compare yields a total order with -0 < +0.
  function automatic pix_t order_key(input pix_t x);
    pix_t sign_mask;
    sign_mask = {1'b1, {(data_width-1){1'b0}}};
    return x[data_width-1] ? ~x : (x | sign_mask);
  endfunction

  // Larger of two pixels under order_key; ties return the identical pattern.
  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (order_key(a) >= order_key(b)) ? a : b;
  endfunction

  logic [CW-1:0] col_r, row_r;
  logic [CW-1:0] col_next_s, row_next_s;
  pix_t          buf1_r [D];   // row r-1
  pix_t          buf2_r [D];   // row r-2
  pix_t          win0_r, win1_r; // column maxima of cols c-1 and c-2
  pix_t          col_max_s, win_max_s;
  logic          fire_s;

  // Vertical triple maximum, window maximum and window-fire decode.
  always_comb begin
    col_max_s = max2(max2(buf2_r[col_r], buf1_r[col_r]), pxl_in);
    win_max_s = max2(max2(win1_r, win0_r), col_max_s);
    fire_s    = valid_in
              && (row_r >= CW'(2)) && (row_r[0] == 1'b0)
              && (col_r >= CW'(2)) && (col_r[0] == 1'b0);
  end

  // Raster position of the next accepted pixel; wraps to (0,0) after a frame.
  always_comb begin
    col_next_s = col_r;
    row_next_s = row_r;
    if (col_r == CW'(D - 1)) begin
      col_next_s = {CW{1'b0}};
      if (row_r == CW'(D - 1)) begin
        row_next_s = {CW{1'b0}};
      end else begin
        row_next_s = row_r + CW'(1);
      end
    end else begin
      col_next_s = col_r + CW'(1);
    end
  end

  // Line buffers: shift row r-1 into row r-2 and store the new pixel. Contents
  // are not reset; rows 0 and 1 of every frame overwrite them before use.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      buf2_r[col_r] <= buf1_r[col_r];
      buf1_r[col_r] <= pxl_in;
    end
  end

  // Counters, column-maximum window and registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_r     <= {CW{1'b0}};
      row_r     <= {CW{1'b0}};
      win0_r    <= {data_width{1'b0}};
      win1_r    <= {data_width{1'b0}};
      pxl_out   <= {data_width{1'b0}};
      valid_out <= 1'b0;
    end else begin
      valid_out <= fire_s;
      if (valid_in) begin
        col_r  <= col_next_s;
        row_r  <= row_next_s;
        win1_r <= win0_r;
        win0_r <= col_max_s;
      end
      if (fire_s) begin
        pxl_out <= win_max_s;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_33.sv
module tb_max_pool_33;

  localparam int D    = 5;
  localparam int NPIX = D * D;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic [31:0] pxl_out;
  logic        valid_out;

  always #5 clk = ~clk;

  max_pool_33 #(.D(D), .data_width(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .pxl_in   (pxl_in),
    .pxl_out  (pxl_out),
    .valid_out(valid_out)
  );

  typedef struct {
    int              pat;
    bit              gaps;
    logic [3:0][31:0] expv;   // expv[0] is the first window
  } vec_t;

  logic [31:0] sb[$];     // scoreboard of expected outputs
  logic [31:0] texp[$];   // table-supplied expectations override the golden model
  logic [31:0] fr[NPIX];  // current frame, for the golden model
  int          n_vec = 0;
  int          n_bad = 0;
  logic        exp_v;
  logic [31:0] last_out;
  int          brow, bcol;

  function automatic logic [31:0] okey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  // Golden 3x3 maximum of the window whose bottom-right pixel is (r,c).
  function automatic logic [31:0] gold(input int r, input int c);
    logic [31:0] m;
    m = fr[(r-2)*D + (c-2)];
    for (int i = r-2; i <= r; i++)
      for (int j = c-2; j <= c; j++)
        if (okey(fr[i*D + j]) > okey(m)) m = fr[i*D + j];
    return m;
  endfunction

  function automatic logic [31:0] gen(input int pat, input int i);
    case (pat)
      0: return 32'(i);
      1: return (i == 6) ? 32'hBF00_0000 : 32'hBF80_0000;
      2: return (i == 0) ? 32'h0000_0000 : ((i == 24) ? 32'hBF80_0000 : 32'h8000_0000);
      default: return $urandom;
    endcase
  endfunction

  // Compare the DUT outputs produced by the previous rising edge.
  task automatic check_out();
    logic [31:0] e;
    n_vec++;
    if (valid_out !== exp_v) begin
      n_bad++;
      $display("FAIL valid_out: got %b expected %b (t=%0t)", valid_out, exp_v, $time);
    end
    if (valid_out === 1'b1 || exp_v) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: got output %h with nothing expected", pxl_out);
      end else begin
        e = sb.pop_front();
        if (pxl_out !== e) begin
          n_bad++;
          $display("FAIL pxl_out: got %h expected %h (t=%0t)", pxl_out, e, $time);
        end
        last_out = e;
      end
    end else begin
      n_vec++;
      if (pxl_out !== last_out) begin
        n_bad++;
        $display("FAIL pxl_out_hold: got %h expected %h", pxl_out, last_out);
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] p);
    @(negedge clk);
    check_out();
    reset    = 1'b1;
    valid_in = v;
    pxl_in   = p;
    exp_v    = 1'b0;
    if (v) begin
      if (brow >= 2 && brow % 2 == 0 && bcol >= 2 && bcol % 2 == 0) begin
        exp_v = 1'b1;
        if (texp.size() > 0) sb.push_back(texp.pop_front());
        else                 sb.push_back(gold(brow, bcol));
      end
      if (bcol == D-1) begin
        bcol = 0;
        brow = (brow == D-1) ? 0 : brow + 1;
      end else begin
        bcol++;
      end
    end
  endtask

  task automatic drive_frame(input int pat, input bit gaps);
    logic [31:0] p;
    for (int i = 0; i < NPIX; i++) begin
      p = gen(pat, i);
      fr[i] = p;
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 2)) step(1'b0, $urandom);
      step(1'b1, p);
    end
  endtask

  // One reset cycle with a tempting pixel on the input that must be ignored.
  task automatic do_reset();
    @(negedge clk);
    check_out();
    reset    = 1'b0;
    valid_in = 1'b1;
    pxl_in   = 32'h7F80_0000;
    exp_v    = 1'b0;
    last_out = 32'h0;
    brow     = 0;
    bcol     = 0;
    texp.delete();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{pat:0, gaps:1'b0, expv:{32'd24, 32'd22, 32'd14, 32'd12}};
    tbl[1] = '{pat:1, gaps:1'b0, expv:{32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF00_0000}};
    tbl[2] = '{pat:2, gaps:1'b0, expv:{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000}};
    tbl[3] = '{pat:0, gaps:1'b1, expv:{32'd24, 32'd22, 32'd14, 32'd12}};
    tbl[4] = '{pat:1, gaps:1'b1, expv:{32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF00_0000}};

    reset    = 1'b0;
    valid_in = 1'b0;
    pxl_in   = 32'h0;
    exp_v    = 1'b0;
    last_out = 32'h0;
    brow     = 0;
    bcol     = 0;
    repeat (2) @(negedge clk);

    // Table frames, fed back to back.
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 4; k++) texp.push_back(tbl[t].expv[k]);
      drive_frame(tbl[t].pat, tbl[t].gaps);
    end

    // Random bit patterns (including NaNs/infinities) checked by the golden model.
    for (int f = 0; f < 3; f++) drive_frame(3, (f == 1));

    // Reset after pixel 13 of a ramp frame, then a fresh ramp frame.
    for (int i = 0; i < 14; i++) begin
      fr[i] = 32'(i);
      step(1'b1, 32'(i));
    end
    do_reset();
    texp.push_back(32'd12);
    texp.push_back(32'd14);
    texp.push_back(32'd22);
    texp.push_back(32'd24);
    drive_frame(0, 1'b0);

    repeat (3) step(1'b0, 32'h0);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d outputs expected but never produced", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
